prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Write side of the CPU's 64x16 instruction store. Accepts a byte stream over a
//  valid/ready handshake and packs byte pairs (high byte first) into 16-bit
//  instruction words. Writes them into an internal 64-entry program RAM. Serves
//  the CPU's fetch port (pc -> op) with the same combinational read timing as the
//  fixed instruction memory, so it replaces it without core changes. Holds the
//  core stopped (cpu_run=0) until a complete program is resident.
// PARAMETERS
//  ADDR_W  6   instruction address width (pc width)
//  DATA_W  16  instruction word width; op[15:12] is the opcode (def.h encodings)
//  DEPTH   64  number of program words; must equal 2**ADDR_W
// PORTS
//  clk       in   1       rising-edge clock
//  rst_n     in   1       synchronous reset, active low
//  start     in   1       one-cycle pulse; begins a load of len words
//  len       in   7       word count for this load, legal range 1..64; sampled on start
//  rx_data   in   8       incoming program byte
//  rx_valid  in   1       rx_data is valid
//  rx_ready  out  1       loader accepts a byte this cycle
//  pc        in   ADDR_W  CPU fetch address
//  op        out  DATA_W  instruction at pc (combinational)
//  busy      out  1       load in progress
//  done      out  1       program resident (level)
//  cpu_run   out  1       release for the CPU core; equals done
//  err       out  1       one-cycle pulse: start with an illegal len
// BEHAVIOUR
//  - Handshake: a byte transfers on a cycle with rx_valid & rx_ready. rx_data and
//    rx_valid must stay stable while rx_valid=1 and rx_ready=0.
//  - FSM states: IDLE, LOAD_HI, LOAD_LO, DONE.
//    IDLE:
//      - start with len in 1..64: len_q<=len, waddr<=0, go to LOAD_HI.
//      - start with len=0 or len>64: err=1 for 1 cycle, stay in IDLE.
//    LOAD_HI:
//      - rx_ready=1. On transfer, hi_q<=rx_data, go to LOAD_LO.
//    LOAD_LO:
//      - rx_ready=1. On transfer, mem[waddr]<={hi_q,rx_data}.
//      - If waddr==len_q-1, go to DONE. Otherwise waddr<=waddr+1, go to LOAD_HI.
//    DONE:
//      - done=1, cpu_run=1, rx_ready=0.
//      - start: legal len reloads (same as from IDLE; cpu_run drops the next cycle);
//        illegal len pulses err and stays in DONE.
//  - start during LOAD_HI/LOAD_LO is ignored; no abort other than rst_n.
//  - busy=1 exactly in LOAD_HI and LOAD_LO.
//  - Latency: the final word is written at the LOAD_LO transfer edge. done and
//    cpu_run rise on that same edge and read the new word on the next cycle.
//  - Read port: op=mem[pc] when cpu_run=1 and pc<len_q. Otherwise op=16'h0000.
//    Unloaded and out-of-range words read as zero; no RAM clear is needed.
//  - len=64: waddr reaches 63 and does not wrap; DONE is entered from waddr==63.
//  - Reset values (applied on rst_n=0 at clk edge, including mid-load):
//    state=IDLE, rx_ready=0, busy=0, done=0, cpu_run=0, err=0, len_q=0, waddr=0,
//    hi_q=0. RAM contents are not reset; reads gate to 0 through len_q=0.
// STRUCTURE
//  - Opcode encodings (LI, INC, COMP, JNZ, ...) stay in def.h; this block does not
//    decode them.
//  - FSM state encodings go as localparams in a new shared loaderdef.h.
//  - One sub-module: prog_ram (DEPTH x DATA_W, synchronous write, asynchronous
//    read). The FSM, packing and read gating stay in prog_loader.
// TESTING
//  1. Reset then start, len=5. Stream 12 08 11 00 20 10 30 01 40 02.
//     -> pc 0..4 read 1208,1100,2010,3001,4002; done=1 after the 10th byte.
//  2. Backpressure: toggle rx_valid randomly during load of len=3.
//     -> Exactly 6 transfers; words are correct; rx_ready=0 in IDLE and DONE.
//  3. start with len=0, then with len=65.
//     -> err pulses 1 cycle each; state stays IDLE; busy=0; op=0000.
//  4. Full load, len=64, bytes = address pattern.
//     -> mem[63] correct; done=1; waddr does not wrap; pc=63 reads the last word.
//  5. After a len=5 load, read pc=5 -> 0000.
//     Reload len=2 -> cpu_run=0 during load, pc=2 -> 0000 after done.
//  6. Assert rst_n=0 after the 3rd byte of a load.
//     -> All outputs return to reset values. A new start with len=1 loads cleanly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_pkg
//  Purpose  : Shared sizes, loader FSM state encodings and helper functions
//             for the program loader (byte stream -> 64x16 instruction store).
//  Contents : ADDR_W / DATA_W / DEPTH / LEN_W sizing constants,
//             loader_state_t FSM encoding, len_is_legal() helper.
//  Revision : 1.0  initial release
// ============================================================================
package prog_loader_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;
    localparam int BYTE_W = 8;

    // One bit wider than the address so that a full-depth length (64) fits.
    localparam int LEN_W  = ADDR_W + 1;

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD_HI = 2'd1,
        ST_LOAD_LO = 2'd2,
        ST_DONE    = 2'd3
    } loader_state_t;

    // A load length is accepted only in the range 1..DEPTH.
    function automatic logic len_is_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= C_MAX_LEN);
    endfunction

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Interface : prog_loader_if
//  Purpose   : Byte-stream valid/ready channel feeding the program loader.
//  Signals   : data  - program byte
//              valid - data is valid (held stable until accepted)
//              ready - receiver accepts a byte this cycle
//  Modports  : master (byte source), slave (loader side)
//  Revision  : 1.0  initial release
// ============================================================================
interface prog_loader_if #(
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface : prog_loader_if
`default_nettype wire

// File: rtl/prog_ram.sv
`default_nettype none
// ============================================================================
//  Module   : prog_ram
//  Purpose  : DEPTH x DATA_W program store, synchronous write, asynchronous
//             (combinational) read. Contents are not reset.
//  Ports    : clk      - rising-edge clock
//             we_i     - write enable
//             waddr_i  - write address
//             wdata_i  - write data
//             raddr_i  - read address
//             rdata_o  - read data (combinational from raddr_i)
//  Revision : 1.0  initial release
// ============================================================================
module prog_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  wire logic              clk,
    input  wire logic              we_i,
    input  wire logic [ADDR_W-1:0] waddr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic [ADDR_W-1:0] raddr_i,
    output logic      [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : prog_ram
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Write side of the CPU instruction store. Packs a byte stream
//             (high byte first) into 16-bit words, writes them into a
//             64-entry program RAM and serves the CPU fetch port with
//             combinational read timing. Holds the core stopped until a
//             complete program is resident.
//  Ports    : clk        - rising-edge clock
//             rst_n      - synchronous reset, active low
//             start_i    - one-cycle pulse, begins a load of len_i words
//             len_i      - word count (legal 1..DEPTH), sampled on start_i
//             rx         - byte stream channel (slave modport)
//             pc_i       - CPU fetch address
//             op_o       - instruction at pc_i (combinational, gated)
//             busy_o     - load in progress
//             done_o     - program resident (level)
//             cpu_run_o  - CPU release, equals done_o
//             err_o      - one-cycle pulse after start_i with illegal len_i
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = prog_loader_pkg::ADDR_W,
    parameter int DATA_W = prog_loader_pkg::DATA_W,
    parameter int DEPTH  = prog_loader_pkg::DEPTH
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start_i,
    input  wire logic [LEN_W-1:0]  len_i,
    prog_loader_if.slave           rx,
    input  wire logic [ADDR_W-1:0] pc_i,
    output logic      [DATA_W-1:0] op_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   cpu_run_o,
    output logic                   err_o
);

    loader_state_t      state_q, state_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [BYTE_W-1:0]  hi_q,    hi_d;
    logic               err_q,   err_d;

    logic               rx_ready;
    logic               xfer;
    logic               last_word;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;
    logic               in_range;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            waddr_q <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            waddr_q <= waddr_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

    assign rx_ready  = (state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO);
    assign xfer      = rx.valid && rx_ready;
    // len_q is at least 1 whenever a load is active, so len_q-1 never wraps.
    assign last_word = ({1'b0, waddr_q} == (len_q - LEN_W'(1)));
    assign ram_wdata = {hi_q, rx.data};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        waddr_d = waddr_q;
        hi_d    = hi_q;
        err_d   = 1'b0;
        ram_we  = 1'b0;

        case (state_q)
            // A start is honoured identically from IDLE and DONE; a reload
            // from DONE drops cpu_run on the next cycle via the state change.
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    if (len_is_legal(len_i)) begin
                        len_d   = len_i;
                        waddr_d = '0;
                        state_d = ST_LOAD_HI;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end

            ST_LOAD_HI: begin
                if (xfer) begin
                    hi_d    = rx.data;
                    state_d = ST_LOAD_LO;
                end
            end

            ST_LOAD_LO: begin
                if (xfer) begin
                    ram_we = 1'b1;
                    if (last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        waddr_d = waddr_q + ADDR_W'(1);
                        state_d = ST_LOAD_HI;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Program RAM
    // ------------------------------------------------------------------
    prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_prog_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (waddr_q),
        .wdata_i (ram_wdata),
        .raddr_i (pc_i),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Reads beyond the loaded length (and everything before the first load,
    // where len_q is 0) return zero, so the RAM never needs clearing.
    assign in_range  = ({1'b0, pc_i} < len_q);
    assign done_o    = (state_q == ST_DONE);
    assign cpu_run_o = done_o;
    assign busy_o    = rx_ready;
    assign err_o     = err_q;
    assign rx.ready  = rx_ready;
    assign op_o      = (done_o && in_range) ? ram_rdata : '0;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Directed self-checking bench for prog_loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  len;
    logic [5:0]  pc;
    logic [15:0] op;
    logic        busy;
    logic        done;
    logic        cpu_run;
    logic        err;

    int checks;
    int failures;
    int xfer_cnt;

    prog_loader_if rx_if ();

    prog_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .len_i     (len),
        .rx        (rx_if.slave),
        .pc_i      (pc),
        .op_o      (op),
        .busy_o    (busy),
        .done_o    (done),
        .cpu_run_o (cpu_run),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_if.valid && rx_if.ready) xfer_cnt <= xfer_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic do_start(input logic [6:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte after 'gap' idle cycles; returns at the negedge
    // following the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            rx_if.valid = 1'b0;
            rx_if.data  = 8'hEE;
            @(negedge clk);
        end
        rx_if.valid = 1'b1;
        rx_if.data  = b;
        n = 0;
        while (!rx_if.ready && n <= 50) begin
            @(negedge clk);
            n++;
        end
        if (n > 50) check("ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        rx_if.valid = 1'b0;
    endtask

    task automatic read_pc(input logic [5:0] a, input logic [15:0] exp, input string tag);
        pc = a;
        #1;
        check(tag, {16'h0, op}, {16'h0, exp});
    endtask

    int base;

    initial begin
        checks      = 0;
        failures    = 0;
        xfer_cnt    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        len         = '0;
        pc          = '0;
        rx_if.valid = 1'b0;
        rx_if.data  = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready",   {31'h0, rx_if.ready}, 32'd0);
        check("rst_busy",    {31'h0, busy},        32'd0);
        check("rst_done",    {31'h0, done},        32'd0);
        check("rst_cpu_run", {31'h0, cpu_run},     32'd0);
        check("rst_err",     {31'h0, err},         32'd0);
        read_pc(6'd0, 16'h0000, "rst_op");

        // ---------------- illegal lengths from IDLE ----------------
        do_start(7'd0);
        check("len0_err",   {31'h0, err},  32'd1);
        check("len0_busy",  {31'h0, busy}, 32'd0);
        @(negedge clk);
        check("len0_err_off", {31'h0, err}, 32'd0);
        do_start(7'd65);
        check("len65_err",  {31'h0, err},  32'd1);
        check("len65_busy", {31'h0, busy}, 32'd0);
        check("len65_done", {31'h0, done}, 32'd0);
        check("len65_ready", {31'h0, rx_if.ready}, 32'd0);
        @(negedge clk);
        check("len65_err_off", {31'h0, err}, 32'd0);
        read_pc(6'd0, 16'h0000, "len65_op");

        // ---------------- basic load, len=5 ----------------
        do_start(7'd5);
        check("t1_busy",    {31'h0, busy},        32'd1);
        check("t1_ready",   {31'h0, rx_if.ready}, 32'd1);
        check("t1_cpu_run", {31'h0, cpu_run},     32'd0);
        base = xfer_cnt;
        send_byte(8'h12, 0); send_byte(8'h08, 0);
        send_byte(8'h11, 0); send_byte(8'h00, 0);
        send_byte(8'h20, 0); send_byte(8'h10, 0);
        send_byte(8'h30, 0); send_byte(8'h01, 0);
        send_byte(8'h40, 0);
        check("t1_done_early", {31'h0, done}, 32'd0);
        send_byte(8'h02, 0);
        check("t1_xfers",   32'(xfer_cnt - base), 32'd10);
        check("t1_done",    {31'h0, done},        32'd1);
        check("t1_cpu_run_on", {31'h0, cpu_run},  32'd1);
        check("t1_busy_off", {31'h0, busy},       32'd0);
        check("t1_ready_off", {31'h0, rx_if.ready}, 32'd0);
        read_pc(6'd0, 16'h1208, "t1_pc0");
        read_pc(6'd1, 16'h1100, "t1_pc1");
        read_pc(6'd2, 16'h2010, "t1_pc2");
        read_pc(6'd3, 16'h3001, "t1_pc3");
        read_pc(6'd4, 16'h4002, "t1_pc4");
        read_pc(6'd5, 16'h0000, "t1_pc5");

        // valid held in DONE must not transfer
        base = xfer_cnt;
        rx_if.valid = 1'b1;
        rx_if.data  = 8'h55;
        repeat (3) @(negedge clk);
        rx_if.valid = 1'b0;
        check("done_no_xfer", 32'(xfer_cnt - base), 32'd0);

        // illegal start in DONE: err pulse, stays DONE
        do_start(7'd65);
        check("done_len65_err",  {31'h0, err},  32'd1);
        check("done_len65_done", {31'h0, done}, 32'd1);
        @(negedge clk);
        check("done_len65_err_off", {31'h0, err}, 32'd0);
        read_pc(6'd4, 16'h4002, "done_len65_pc4");

        // ---------------- backpressure, len=3 ----------------
        do_start(7'd3);
        check("t2_cpu_run", {31'h0, cpu_run}, 32'd0);
        read_pc(6'd0, 16'h0000, "t2_op_gated");
        base = xfer_cnt;
        send_byte(8'hAB, int'($urandom_range(0, 3)));
        send_byte(8'hCD, int'($urandom_range(0, 3)));
        send_byte(8'h12, int'($urandom_range(0, 3)));
        send_byte(8'h34, int'($urandom_range(0, 3)));
        check("t2_busy_mid", {31'h0, busy}, 32'd1);
        send_byte(8'h56, int'($urandom_range(0, 3)));
        send_byte(8'h78, int'($urandom_range(0, 3)));
        repeat (2) @(negedge clk);
        check("t2_xfers", 32'(xfer_cnt - base), 32'd6);
        check("t2_done",  {31'h0, done}, 32'd1);
        check("t2_ready_off", {31'h0, rx_if.ready}, 32'd0);
        read_pc(6'd0, 16'hABCD, "t2_pc0");
        read_pc(6'd1, 16'h1234, "t2_pc1");
        read_pc(6'd2, 16'h5678, "t2_pc2");
        read_pc(6'd3, 16'h0000, "t2_pc3");

        // ---------------- reload, len=2 ----------------
        do_start(7'd2);
        check("t5_cpu_run", {31'h0, cpu_run}, 32'd0);
        send_byte(8'h0F, 0); send_byte(8'hF0, 0);
        check("t5_cpu_run_mid", {31'h0, cpu_run}, 32'd0);
        send_byte(8'hA5, 0); send_byte(8'h5A, 0);
        check("t5_done", {31'h0, done}, 32'd1);
        read_pc(6'd0, 16'h0FF0, "t5_pc0");
        read_pc(6'd1, 16'hA55A, "t5_pc1");
        read_pc(6'd2, 16'h0000, "t5_pc2");

        // ---------------- full load, len=64 ----------------
        do_start(7'd64);
        base = xfer_cnt;
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i), 0);
            send_byte(8'(i + 8'h80), 0);
        end
        check("t4_xfers", 32'(xfer_cnt - base), 32'd128);
        check("t4_done",  {31'h0, done}, 32'd1);
        check("t4_busy",  {31'h0, busy}, 32'd0);
        read_pc(6'd0,  16'h0080, "t4_pc0");
        read_pc(6'd32, 16'h20A0, "t4_pc32");
        read_pc(6'd62, 16'h3EBE, "t4_pc62");
        read_pc(6'd63, 16'h3FBF, "t4_pc63");

        // ---------------- reset mid-load ----------------
        do_start(7'd4);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_ready",   {31'h0, rx_if.ready}, 32'd0);
        check("t6_busy",    {31'h0, busy},        32'd0);
        check("t6_done",    {31'h0, done},        32'd0);
        check("t6_cpu_run", {31'h0, cpu_run},     32'd0);
        check("t6_err",     {31'h0, err},         32'd0);
        read_pc(6'd0, 16'h0000, "t6_op");
        rst_n = 1'b1;
        @(negedge clk);
        do_start(7'd1);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        check("t6_done_after", {31'h0, done}, 32'd1);
        read_pc(6'd0, 16'h1234, "t6_pc0");
        read_pc(6'd1, 16'h0000, "t6_pc1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
